// File: rtl/mul_seq_rv32m.sv
// RV32M multiply sequencer: converts signed operands to magnitudes for an external
// unsigned 32x32 multiplier, waits LAT cycles, then sign-corrects and returns a 32-bit half.
module mul_seq_rv32m #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] mul_op1,
  output logic [31:0] mul_op2,
  input  logic [63:0] mul_res,
  output logic        busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [3:0] LAT_C     = 4'(LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_neg, w_neg_nxt;
  logic        r_hi, w_hi_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_op1, w_op1_nxt;
  logic [31:0] r_op2, w_op2_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        w_s1, w_s2;
  logic [63:0] w_prod;

  assign w_s1   = ((req_op == OP_MULH) || (req_op == OP_MULHSU)) && req_rs1[31];
  assign w_s2   = (req_op == OP_MULH) && req_rs2[31];
  assign w_prod = r_neg ? (64'd0 - mul_res) : mul_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_hi        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_neg       <= w_neg_nxt;
      r_hi        <= w_hi_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_op1       <= w_op1_nxt;
      r_op2       <= w_op2_nxt;
      r_data      <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_neg_nxt       = r_neg;
    w_hi_nxt        = r_hi;
    w_rsp_valid_nxt = r_rsp_valid;
    w_op1_nxt       = r_op1;
    w_op2_nxt       = r_op2;
    w_data_nxt      = r_data;
    // Flush outranks everything, including a request arriving in the same cycle.
    if (flush) begin
      w_state_nxt     = S_IDLE;
      w_rsp_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          w_op1_nxt   = w_s1 ? (32'd0 - req_rs1) : req_rs1;
          w_op2_nxt   = w_s2 ? (32'd0 - req_rs2) : req_rs2;
          w_neg_nxt   = w_s1 ^ w_s2;
          w_hi_nxt    = (req_op != OP_MUL);
          w_cnt_nxt   = LAT_C;
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_data_nxt      = r_hi ? w_prod[63:32] : w_prod[31:0];
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end
        end
        S_DONE: if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_data;
  assign mul_op1   = r_op1;
  assign mul_op2   = r_op2;

endmodule

// File: tb/tb_mul_seq_rv32m.sv
// Directed bench for mul_seq_rv32m: three instances (LAT=2, 1, 4) each driving a
// behavioural unsigned multiplier; expected results are hand-computed constants.
module tb_mul_seq_rv32m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rop = 2'b00;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [2:0]  rv = '0;
  logic [2:0]  rrdy, rvld, bsy;
  logic [2:0][31:0] dat, op1, op2;
  logic [2:0][63:0] mres;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_mul
    assign mres[k] = {32'd0, op1[k]} * {32'd0, op2[k]};
  end

  mul_seq_rv32m #(.LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(rv[0]), .req_ready(rrdy[0]),
    .req_op(rop), .req_rs1(rs1), .req_rs2(rs2), .rsp_valid(rvld[0]), .rsp_ready(rsp_ready),
    .rsp_data(dat[0]), .mul_op1(op1[0]), .mul_op2(op2[0]), .mul_res(mres[0]), .busy(bsy[0]));
  mul_seq_rv32m #(.LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(rv[1]), .req_ready(rrdy[1]),
    .req_op(rop), .req_rs1(rs1), .req_rs2(rs2), .rsp_valid(rvld[1]), .rsp_ready(rsp_ready),
    .rsp_data(dat[1]), .mul_op1(op1[1]), .mul_op2(op2[1]), .mul_res(mres[1]), .busy(bsy[1]));
  mul_seq_rv32m #(.LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(rv[2]), .req_ready(rrdy[2]),
    .req_op(rop), .req_rs1(rs1), .req_rs2(rs2), .rsp_valid(rvld[2]), .rsp_ready(rsp_ready),
    .rsp_data(dat[2]), .mul_op1(op1[2]), .mul_op2(op2[2]), .mul_res(mres[2]), .busy(bsy[2]));

  // Issue one request on instance k; returns data and accept-to-valid latency (-1 on timeout).
  task automatic issue(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output int lat);
    @(negedge clk);
    rop = op; rs1 = a; rs2 = b; rv[k] = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rv[k] = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rvld[k]) begin lat = n; break; end
    end
    d = dat[k];
  endtask

  task automatic take(input int k);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({rrdy[k], rvld[k], bsy[k]} !== 3'b100 || dat[k] !== 32'd0 || op1[k] !== 32'd0 || op2[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset inst%0d: rdy/vld/busy=%b data=%h op1=%h op2=%h, want 100 and zeros",
                 k, {rrdy[k], rvld[k], bsy[k]}, dat[k], op1[k], op2[k]);
      end
    end
  endtask

  task automatic test_allones;
    logic [31:0] d; int lat;
    issue(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, d, lat);
    n_chk++; if (d !== 32'hFFFFFFFE || lat !== 2) begin n_fail++;
      $display("FAIL mulhu_ones: data=%h lat=%0d, want fffffffe lat 2", d, lat); end
    take(0);
    n_chk++; if (rvld[0] !== 1'b0 || rrdy[0] !== 1'b1) begin n_fail++;
      $display("FAIL mulhu_release: vld=%b rdy=%b, want 0 1", rvld[0], rrdy[0]); end
    issue(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, d, lat);
    n_chk++; if (d !== 32'h00000001) begin n_fail++;
      $display("FAIL mul_ones: data=%h, want 00000001", d); end
    take(0);
  endtask

  task automatic test_mulh_minneg;
    logic [31:0] d; int lat;
    issue(0, 2'b01, 32'h80000000, 32'h80000000, d, lat);
    n_chk++; if (d !== 32'h40000000) begin n_fail++;
      $display("FAIL mulh_minneg: data=%h, want 40000000", d); end
    n_chk++; if (op1[0] !== 32'h80000000 || op2[0] !== 32'h80000000) begin n_fail++;
      $display("FAIL mulh_minneg_ops: op1=%h op2=%h, want 80000000 80000000", op1[0], op2[0]); end
    take(0);
  endtask

  task automatic test_mixed;
    logic [31:0] d; int lat;
    issue(0, 2'b01, 32'hFFFFFFFD, 32'd5, d, lat);
    n_chk++; if (d !== 32'hFFFFFFFF || op1[0] !== 32'd3 || op2[0] !== 32'd5) begin n_fail++;
      $display("FAIL mulh_m3x5: data=%h op1=%h op2=%h, want ffffffff 3 5", d, op1[0], op2[0]); end
    take(0);
    issue(0, 2'b00, 32'hFFFFFFFD, 32'd5, d, lat);
    n_chk++; if (d !== 32'hFFFFFFF1) begin n_fail++;
      $display("FAIL mul_m3x5: data=%h, want fffffff1", d); end
    take(0);
    issue(0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, d, lat);
    n_chk++; if (d !== 32'hFFFFFFFF || op1[0] !== 32'd1 || op2[0] !== 32'hFFFFFFFF) begin n_fail++;
      $display("FAIL mulhsu: data=%h op1=%h op2=%h, want ffffffff 1 ffffffff", d, op1[0], op2[0]); end
    take(0);
    issue(0, 2'b01, 32'd0, 32'hFFFFFFFF, d, lat);
    n_chk++; if (d !== 32'd0) begin n_fail++;
      $display("FAIL mulh_zero: data=%h, want 0", d); end
    take(0);
  endtask

  task automatic test_latency;
    logic [31:0] d; int lat;
    issue(1, 2'b11, 32'h00010000, 32'h00030000, d, lat);
    n_chk++; if (d !== 32'd3 || lat !== 1) begin n_fail++;
      $display("FAIL lat1: data=%h lat=%0d, want 3 lat 1", d, lat); end
    take(1);
  endtask

  task automatic test_backpressure;
    logic [31:0] d; int lat; logic ok;
    issue(2, 2'b00, 32'd1234, 32'd1000, d, lat);
    n_chk++; if (d !== 32'd1234000 || lat !== 4) begin n_fail++;
      $display("FAIL lat4: data=%0d lat=%0d, want 1234000 lat 4", d, lat); end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rvld[2] !== 1'b1 || dat[2] !== 32'd1234000 || rrdy[2] !== 1'b0) ok = 1'b0;
    end
    n_chk++; if (!ok) begin n_fail++;
      $display("FAIL backpressure_hold: vld=%b data=%0d rdy=%b, want 1 1234000 0", rvld[2], dat[2], rrdy[2]); end
    @(negedge clk); rsp_ready = 1'b1; rv[2] = 1'b1; rop = 2'b00; rs1 = 32'd7; rs2 = 32'd6;
    @(posedge clk); #1; rsp_ready = 1'b0;
    n_chk++; if (rvld[2] !== 1'b0 || bsy[2] !== 1'b0 || rrdy[2] !== 1'b1) begin n_fail++;
      $display("FAIL handshake_edge: vld=%b busy=%b rdy=%b, want 0 0 1", rvld[2], bsy[2], rrdy[2]); end
    @(posedge clk); #1; rv[2] = 1'b0;
    n_chk++; if (bsy[2] !== 1'b1 || op1[2] !== 32'd7) begin n_fail++;
      $display("FAIL next_accept: busy=%b op1=%0d, want 1 7", bsy[2], op1[2]); end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (rvld[2]) begin lat = n; break; end
    end
    n_chk++; if (dat[2] !== 32'd42 || lat !== 4) begin n_fail++;
      $display("FAIL back_to_back: data=%0d lat=%0d, want 42 lat 4", dat[2], lat); end
    take(2);
  endtask

  task automatic test_flush;
    logic [31:0] d; int lat; logic seen;
    @(negedge clk); rop = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; rv[0] = 1'b1;
    @(posedge clk); #1; rv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk); flush = 1'b1; rv[0] = 1'b1;
    @(posedge clk); #1; flush = 1'b0; rv[0] = 1'b0;
    n_chk++; if (bsy[0] !== 1'b0 || rvld[0] !== 1'b0) begin n_fail++;
      $display("FAIL flush_idle: busy=%b vld=%b, want 0 0", bsy[0], rvld[0]); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (rvld[0] || bsy[0]) seen = 1'b1; end
    n_chk++; if (seen) begin n_fail++;
      $display("FAIL flush_quiet: saw activity=%b, want 0", seen); end
    issue(0, 2'b01, 32'hFFFFFFFE, 32'd3, d, lat);
    n_chk++; if (d !== 32'hFFFFFFFF || lat !== 2) begin n_fail++;
      $display("FAIL after_flush: data=%h lat=%0d, want ffffffff lat 2", d, lat); end
    take(0);
  endtask

  task automatic test_async_reset;
    logic [31:0] d; int lat;
    issue(2, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, d, lat);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    n_chk++; if (rvld[2] !== 1'b0 || bsy[2] !== 1'b0 || dat[2] !== 32'd0 || op1[2] !== 32'd0 || op2[2] !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: vld=%b busy=%b data=%h op1=%h op2=%h, want 0 0 zeros",
               rvld[2], bsy[2], dat[2], op1[2], op2[2]);
    end
    @(negedge clk); rst_n = 1'b1;
    issue(2, 2'b00, 32'd9, 32'd9, d, lat);
    n_chk++; if (d !== 32'd81 || lat !== 4) begin n_fail++;
      $display("FAIL post_reset_op: data=%0d lat=%0d, want 81 lat 4", d, lat); end
    take(2);
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_allones;
    test_mulh_minneg;
    test_mixed;
    test_latency;
    test_backpressure;
    test_flush;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_rv32m.md
# mul_seq_rv32m

Sequencer that runs RV32M multiply instructions (MUL, MULH, MULHSU, MULHU) on the shared 32x32 unsigned Wallace-tree multiplier. It sits between the execute-stage issue logic and the multiplier. It turns signed operands into magnitudes, holds them stable for a programmable multicycle settle window, applies sign correction to the 64-bit product, and returns the selected 32-bit half over a valid/ready handshake. The multiplier is instantiated outside this block; this block only drives its operands and samples its product.

## Interface
- `LAT`, default 2: number of cycles the multiplier operands are held before `mul_res` is sampled. Legal range is 1..15.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `flush` input, 1 bit: synchronous abort of any in-flight operation.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block can accept a request.
- `req_op` input, 2 bits: operation select; 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_rs1` input, 32 bits: first operand.
- `req_rs2` input, 32 bits: second operand.
- `rsp_valid` output, 1 bit: result present.
- `rsp_ready` input, 1 bit: consumer accepts the result.
- `rsp_data` output, 32 bits: result.
- `mul_op1` output, 32 bits: unsigned operand driven to the multiplier.
- `mul_op2` output, 32 bits: unsigned operand driven to the multiplier.
- `mul_res` input, 64 bits: unsigned product returned by the multiplier.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- **IDLE**
  - `req_ready` is 1.
  - On `req_valid & req_ready` (the accept edge), the block registers:
    - sign flags: `s1 = (op==MULH | op==MULHSU) & rs1[31]` and `s2 = (op==MULH) & rs2[31]`;
    - `mul_op1 = s1 ? -rs1 : rs1` and `mul_op2 = s2 ? -rs2 : rs2`, each 32-bit two's complement;
    - `neg = s1 ^ s2`;
    - `hi = (op != MUL)`;
    - counter `cnt = LAT`.
  - It then moves to WAIT.
- **WAIT**
  - `cnt` decrements once per cycle.
  - On the edge where `cnt == 1`, the block computes `p = neg ? -mul_res : mul_res` (64-bit two's complement).
  - It registers `rsp_data = hi ? p[63:32] : p[31:0]` and moves to DONE.
- **DONE**
  - `rsp_valid` is 1.
  - `rsp_data` holds its value until `rsp_valid & rsp_ready`, then the FSM moves to IDLE.
- MUL always treats both operands as unsigned (the low half does not depend on signedness).
- Magnitude of 0x80000000 is 0x80000000; this is a valid unsigned multiplier input.
- `mul_op1` and `mul_op2` hold their values through WAIT, DONE and IDLE. They change only on an accept.
- `req_ready` is 0 in WAIT and DONE. There is no overlap between operations.
- **Flush:** when `flush` is 1 at an edge, the next state is IDLE from any state and `rsp_valid` drops. A request presented in the same cycle as `flush` is not accepted.
- **Reset:** state IDLE, `req_ready` 1 after reset deasserts, `rsp_valid` 0, `busy` 0, `rsp_data`, `mul_op1` and `mul_op2` all 0, `cnt` 0, flags 0.

## Timing
- Accept edge E0. `rsp_valid` rises after edge E0+LAT. Latency is LAT cycles from accept to valid result.
- `mul_res` is sampled at edge E0+LAT, i.e. after LAT full cycles of stable operands. The multiplier path is constrained as an LAT-cycle multicycle path.
- The response handshake edge returns the FSM to IDLE. The earliest next accept is the following edge. Sustained throughput is one operation per LAT+2 cycles.
- All outputs are driven from registers, except `req_ready` and `busy`, which decode the state register only.
- If `rsp_ready` is held at 1 in DONE, the handshake completes in one cycle.
- An asynchronous reset mid-operation discards the operation. No `rsp_valid` is produced for it.

## Test plan
- **MULHU/MUL all-ones:** `rs1 = rs2 = 0xFFFFFFFF`, op MULHU -> `rsp_data` 0xFFFFFFFE after LAT cycles. Same operands with op MUL -> 0x00000001.
- **MULH most-negative:** `rs1 = rs2 = 0x80000000`, op MULH -> 0x40000000; `mul_op1 = mul_op2 = 0x80000000`.
- **Mixed signs:** MULH with `rs1 = 0xFFFFFFFD` (-3) and `rs2 = 5` -> 0xFFFFFFFF; MUL with the same operands -> 0xFFFFFFF1. MULHSU with `rs1 = 0xFFFFFFFF`, `rs2 = 0xFFFFFFFF` -> 0xFFFFFFFF. MULH with `rs1 = 0`, `rs2 = 0xFFFFFFFF` -> 0.
- **Backpressure:** hold `rsp_ready` at 0 for 5 cycles in DONE -> `rsp_valid` stays 1, `rsp_data` is stable, `req_ready` stays 0; next accept occurs exactly 1 edge after the handshake. Run with LAT=1 and LAT=4 and check latency equals LAT.
- **Flush and reset:** assert `flush` in the second WAIT cycle -> IDLE next edge, no `rsp_valid`, next request is correct. Assert `rst_n` low asynchronously in DONE -> `rsp_valid` and `busy` go to 0 immediately, all outputs 0.
